// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment scanner.
// Segment bit positions, scan states and pin polarity helper.
package sseg_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;
    localparam int SEG_W = SEG_G + 1;

    // Widest vector the polarity helper handles; callers truncate.
    localparam int POL_W = 32;

    typedef enum logic {
        BLANK,
        DRIVE
    } scan_state_e;

    function automatic logic [POL_W-1:0] apply_polarity(
        input logic [POL_W-1:0] value,
        input logic             active_low
    );
        return active_low ? ~value : value;
    endfunction

endpackage

// File: rtl/sseg_prescaler.sv
// Slot timer for the scanner: counts clk cycles within one digit slot.
// slot_end flags the last cycle of the slot; clear holds it at zero.
module sseg_prescaler #(
    parameter int SlotCycles = 50000,
    parameter int CntW       = (SlotCycles > 1) ? $clog2(SlotCycles) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    output logic [CntW-1:0] count,
    output logic            slot_end
);

    localparam logic [CntW-1:0] LAST = CntW'(SlotCycles - 1);

    assign slot_end = (count == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear || slot_end) begin
            count <= '0;
        end else begin
            count <= count + CntW'(1);
        end
    end

endmodule

// File: rtl/sseg_scanner.sv
// Time-multiplexed seven-segment driver with per-digit blanking guard.
// The digit bus is snapshotted once per frame so mid-scan writes never tear.
module sseg_scanner
    import sseg_pkg::*;
#(
    parameter int NumDigits    = 6,
    parameter int ClkHz        = 50000000,
    parameter int ScanHz       = 1000,
    parameter int BlankCycles  = 64,
    parameter bit SegActiveLow = 1'b1,
    parameter bit AnActiveLow  = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [SEG_W*NumDigits-1:0] dig,
    input  logic [NumDigits-1:0]       dp,
    output logic [SEG_W-1:0]           seg_out,
    output logic                       dp_out,
    output logic [NumDigits-1:0]       an_out,
    output logic                       frame_tick
);

    localparam int SlotCycles = ClkHz / ScanHz;
    localparam int CntW = (SlotCycles > 1) ? $clog2(SlotCycles) : 1;
    localparam int IdxW = $clog2(NumDigits);

    localparam logic [IdxW-1:0] LAST_IDX = IdxW'(NumDigits - 1);
    localparam logic [CntW-1:0] BLANK_LAST =
        CntW'((BlankCycles > 0) ? BlankCycles - 1 : 0);
    localparam scan_state_e SLOT_START = (BlankCycles > 0) ? BLANK : DRIVE;

    localparam logic [SEG_W-1:0] SEG_OFF =
        SEG_W'(apply_polarity('0, SegActiveLow));
    localparam logic DP_OFF = 1'(apply_polarity('0, SegActiveLow));
    localparam logic [NumDigits-1:0] AN_OFF =
        NumDigits'(apply_polarity('0, AnActiveLow));

    logic [CntW-1:0] count;
    logic            slot_end;
    logic            run;
    logic            first;
    logic            clear;
    logic            capture;
    logic            frame;

    scan_state_e     state, state_n;
    logic [IdxW-1:0] idx, idx_n;

    logic [NumDigits-1:0][SEG_W-1:0] snap, snap_n;
    logic [NumDigits-1:0]            snap_dp, snap_dp_n;

    logic [NumDigits-1:0] an_n;
    logic [SEG_W-1:0]     seg_n;
    logic                 dp_n;

    // First enabled cycle after reset or after enable rises restarts the scan.
    assign first = enable & ~run;
    assign clear = ~enable | first;

    sseg_prescaler #(
        .SlotCycles(SlotCycles),
        .CntW      (CntW)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .count   (count),
        .slot_end(slot_end)
    );

    always_comb begin
        state_n = state;
        idx_n   = idx;
        capture = 1'b0;
        frame   = 1'b0;
        if (!enable) begin
            state_n = BLANK;
            idx_n   = '0;
        end else if (first) begin
            state_n = SLOT_START;
            idx_n   = '0;
            capture = 1'b1;
        end else if (slot_end) begin
            state_n = SLOT_START;
            if (idx == LAST_IDX) begin
                idx_n   = '0;
                frame   = 1'b1;
                capture = 1'b1;
            end else begin
                idx_n = idx + IdxW'(1);
            end
        end else if (state == BLANK && count == BLANK_LAST) begin
            state_n = DRIVE;
        end
    end

    always_comb begin
        snap_n    = capture ? dig : snap;
        snap_dp_n = capture ? dp : snap_dp;
        an_n      = '0;
        seg_n     = '0;
        dp_n      = 1'b0;
        if (enable) begin
            seg_n = snap_n[idx_n];
            dp_n  = snap_dp_n[idx_n];
            if (state_n == DRIVE) begin
                an_n = NumDigits'(1) << idx_n;
            end
        end
    end

    // Pins are driven from next-cycle values so every output is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BLANK;
            idx        <= '0;
            run        <= 1'b0;
            snap       <= '0;
            snap_dp    <= '0;
            frame_tick <= 1'b0;
            an_out     <= AN_OFF;
            seg_out    <= SEG_OFF;
            dp_out     <= DP_OFF;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            run        <= enable;
            snap       <= snap_n;
            snap_dp    <= snap_dp_n;
            frame_tick <= frame;
            an_out     <= NumDigits'(apply_polarity(POL_W'(an_n), AnActiveLow));
            seg_out    <= SEG_W'(apply_polarity(POL_W'(seg_n), SegActiveLow));
            dp_out     <= 1'(apply_polarity(POL_W'(dp_n), SegActiveLow));
        end
    end

endmodule

// File: tb/tb_sseg_scanner.sv
// Directed bench for sseg_scanner: 4 digits, 10-cycle slots,
// one instance with a 2-cycle blanking guard and one with none.
module tb_sseg_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [27:0] dig;
    logic [3:0]  dp;

    logic [6:0] seg0, seg1;
    logic       dp0, dp1;
    logic [3:0] an0, an1;
    logic       ft0, ft1;

    int n_chk  = 0;
    int n_fail = 0;

    logic [6:0] old_d[4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};
    logic [6:0] new_d[4] = '{7'h6D, 7'h7D, 7'h07, 7'h7F};

    always #5 clk = ~clk;

    sseg_scanner #(
        .NumDigits(4), .ClkHz(100), .ScanHz(10), .BlankCycles(2),
        .SegActiveLow(1'b1), .AnActiveLow(1'b1)
    ) u0 (
        .clk(clk), .rst(rst), .enable(enable), .dig(dig), .dp(dp),
        .seg_out(seg0), .dp_out(dp0), .an_out(an0), .frame_tick(ft0)
    );

    sseg_scanner #(
        .NumDigits(4), .ClkHz(100), .ScanHz(10), .BlankCycles(0),
        .SegActiveLow(1'b1), .AnActiveLow(1'b1)
    ) u1 (
        .clk(clk), .rst(rst), .enable(enable), .dig(dig), .dp(dp),
        .seg_out(seg1), .dp_out(dp1), .an_out(an1), .frame_tick(ft1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; dig = '0; dp = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (an0 !== 4'hF || seg0 !== 7'h7F || dp0 !== 1'b1 || ft0 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: an=%h seg=%h dp=%b ft=%b want an=f seg=7f dp=1 ft=0",
                         an0, seg0, dp0, ft0);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (an0 !== 4'hF || seg0 !== 7'h7F || dp0 !== 1'b1 || ft0 !== 1'b0) begin
                n_fail++;
                $display("FAIL disabled_dark: an=%h seg=%h dp=%b ft=%b want an=f seg=7f dp=1 ft=0",
                         an0, seg0, dp0, ft0);
            end
        end
    endtask

    task automatic test_scan();
        logic [3:0] exp_an;
        int s;
        dig = {old_d[3], old_d[2], old_d[1], old_d[0]};
        dp = 4'b0001;
        enable = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            s = k / 10;
            exp_an = (k % 10 < 2) ? 4'hF : ~(4'b0001 << s);
            n_chk++;
            if (an0 !== exp_an || seg0 !== ~old_d[s] || dp0 !== (s != 0) || ft0 !== 1'b0) begin
                n_fail++;
                $display("FAIL scan k=%0d: an=%h seg=%h dp=%b ft=%b want an=%h seg=%h dp=%b ft=0",
                         k, an0, seg0, dp0, ft0, exp_an, ~old_d[s], (s != 0));
            end
        end
        tick();
        n_chk++;
        if (ft0 !== 1'b1 || an0 !== 4'hF || seg0 !== ~old_d[0]) begin
            n_fail++;
            $display("FAIL frame_tick: ft=%b an=%h seg=%h want ft=1 an=f seg=%h",
                     ft0, an0, seg0, ~old_d[0]);
        end
        tick();
        n_chk++;
        if (ft0 !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_tick_width: ft=%b want 0", ft0);
        end
    endtask

    task automatic test_no_tear();
        int s;
        for (int f = 2; f <= 15; f++) tick();
        dig = {new_d[3], new_d[2], new_d[1], new_d[0]};
        for (int f = 16; f < 40; f++) begin
            tick();
            s = f / 10;
            n_chk++;
            if (seg0 !== ~old_d[s] || ft0 !== 1'b0) begin
                n_fail++;
                $display("FAIL no_tear f=%0d: seg=%h ft=%b want seg=%h ft=0",
                         f, seg0, ft0, ~old_d[s]);
            end
        end
        tick();
        n_chk++;
        if (ft0 !== 1'b1 || seg0 !== ~new_d[0] || an0 !== 4'hF) begin
            n_fail++;
            $display("FAIL new_frame: ft=%b seg=%h an=%h want ft=1 seg=%h an=f",
                     ft0, seg0, an0, ~new_d[0]);
        end
        for (int f = 1; f <= 12; f++) tick();
        n_chk++;
        if (seg0 !== ~new_d[1] || an0 !== 4'b1101) begin
            n_fail++;
            $display("FAIL new_digit1: seg=%h an=%h want seg=%h an=d",
                     seg0, an0, ~new_d[1]);
        end
    endtask

    task automatic test_enable_drop();
        for (int f = 13; f <= 22; f++) tick();
        n_chk++;
        if (an0 !== 4'b1011 || seg0 !== ~new_d[2]) begin
            n_fail++;
            $display("FAIL digit2_drive: an=%h seg=%h want an=b seg=%h",
                     an0, seg0, ~new_d[2]);
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (an0 !== 4'hF || seg0 !== 7'h7F || ft0 !== 1'b0) begin
                n_fail++;
                $display("FAIL enable_drop %0d: an=%h seg=%h ft=%b want an=f seg=7f ft=0",
                         i, an0, seg0, ft0);
            end
        end
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_chk++;
            if (an0 !== ((k < 2) ? 4'hF : 4'b1110) || seg0 !== ~new_d[0]) begin
                n_fail++;
                $display("FAIL reenable k=%0d: an=%h seg=%h want an=%h seg=%h",
                         k, an0, seg0, (k < 2) ? 4'hF : 4'b1110, ~new_d[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 3; k <= 13; k++) tick();
        n_chk++;
        if (an0 !== 4'b1101) begin
            n_fail++;
            $display("FAIL digit1_drive: an=%h want d", an0);
        end
        rst = 1'b1;
        tick();
        n_chk++;
        if (an0 !== 4'hF || seg0 !== 7'h7F || ft0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: an=%h seg=%h ft=%b want an=f seg=7f ft=0",
                     an0, seg0, ft0);
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_chk++;
            if (an0 !== ((k < 2) ? 4'hF : 4'b1110) || ft0 !== 1'b0) begin
                n_fail++;
                $display("FAIL restart k=%0d: an=%h ft=%b want an=%h ft=0",
                         k, an0, ft0, (k < 2) ? 4'hF : 4'b1110);
            end
        end
    endtask

    task automatic test_blank0();
        int on_cnt[4] = '{0, 0, 0, 0};
        logic [3:0] exp_an;
        enable = 1'b0;
        tick();
        enable = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            exp_an = ~(4'b0001 << (k / 10));
            for (int j = 0; j < 4; j++) if (an1[j] === 1'b0) on_cnt[j]++;
            n_chk++;
            if (an1 !== exp_an || an1 === 4'hF) begin
                n_fail++;
                $display("FAIL blank0 k=%0d: an=%h want %h", k, an1, exp_an);
            end
        end
        tick();
        n_chk++;
        if (ft1 !== 1'b1 || an1 !== 4'b1110) begin
            n_fail++;
            $display("FAIL blank0_frame: ft=%b an=%h want ft=1 an=e", ft1, an1);
        end
        for (int j = 0; j < 4; j++) begin
            n_chk++;
            if (on_cnt[j] != 10) begin
                n_fail++;
                $display("FAIL blank0_on_time an%0d: %0d cycles want 10", j, on_cnt[j]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_no_tear();
        test_enable_drop();
        test_reset_mid();
        test_blank0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sseg_scanner.md
Name: sseg_scanner

Overview:
- Time-multiplexed seven-segment driver sitting directly downstream of the hex peripheral.
- Consumes the parallel per-digit 7-bit segment bus (digit i on bits [7i+6:7i], bit0=a … bit6=g, active-high) plus per-digit decimal points.
- Drives one shared segment bus and one anode line per digit, with a blanking guard between digits to suppress ghosting.
- Snapshots the input once per frame so a bus write mid-scan never tears the displayed value.

Parameters:
- NumDigits, 6, number of digits scanned; must be ≥2.
- ClkHz, 50000000, clk frequency in Hz.
- ScanHz, 1000, per-digit slot rate; SlotCycles = ClkHz/ScanHz, must be ≥ BlankCycles+1.
- BlankCycles, 64, cycles at the start of each slot with all anodes inactive; may be 0.
- SegActiveLow, 1, if 1 then seg_out/dp_out are inverted at the pins.
- AnActiveLow, 1, if 1 then an_out is inverted at the pins.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- enable  input  1  scan enable; low forces display dark
- dig  input  7*NumDigits  segment patterns from the hex peripheral, active-high
- dp  input  NumDigits  decimal points, active-high
- seg_out  output  7  shared segment lines, polarity per SegActiveLow
- dp_out  output  1  shared decimal point, polarity per SegActiveLow
- an_out  output  NumDigits  one-hot anode select, polarity per AnActiveLow
- frame_tick  output  1  one-cycle pulse when a full frame completes

Behaviour:
- Reset (rst=1 at posedge):
  - slot counter=0, digit index=0, state=BLANK, snapshot registers=0, frame_tick=0.
  - an_out all inactive; seg_out and dp_out inactive (all segments off at pin polarity).
- All outputs are registered; there is no combinational path from dig/dp to pins.
- State BLANK:
  - an_out all inactive; seg_out/dp_out already loaded with snapshot[index].
  - Stays for BlankCycles cycles, then goes to DRIVE.
  - When BlankCycles=0, BLANK lasts 0 cycles: DRIVE is entered on the slot's first cycle.
- State DRIVE:
  - an_out one-hot on bit index; seg_out/dp_out = snapshot[index].
  - Lasts SlotCycles−BlankCycles cycles.
- Slot end:
  - Slot counter wraps from SlotCycles−1 to 0.
  - index increments and state returns to BLANK.
- Frame wrap:
  - At index=NumDigits−1 slot end, index wraps to 0 and frame_tick pulses for exactly one cycle (the cycle slot 0 begins).
  - In that same cycle, dig/dp are captured into the snapshot.
  - The snapshot is also captured on the first enabled cycle after reset or after enable rises.
- Enable:
  - enable=0 for one cycle forces, on the next edge, state=BLANK, index=0, slot counter=0, and an_out inactive; no frame_tick.
  - On re-enable, scanning restarts at digit 0 with a fresh snapshot.
- Simultaneous events: rst has priority over enable; enable=0 has priority over slot/frame wrap.
- Reset mid-slot: immediate return to the reset state on the next edge; no partial frame_tick.
- Width rules:
  - Slot counter width = $clog2(SlotCycles).
  - index width = $clog2(NumDigits).
  - index never holds a value ≥ NumDigits.
- Timing: steady-state frame period is exactly NumDigits*SlotCycles cycles; each anode is active exactly SlotCycles−BlankCycles cycles per frame.

Decomposition:
- Shared package sseg_pkg:
  - segment bit index constants SEG_A..SEG_G (0..6).
  - scan_state_e enum {BLANK, DRIVE}.
  - function apply_polarity(value, active_low).
- One sub-module, sseg_prescaler:
  - parameter SlotCycles; inputs clk, rst, clear.
  - outputs count and slot_end (pulse at count=SlotCycles−1).
- sseg_scanner instantiates sseg_prescaler and holds the state machine, index and snapshot.

Test Plan (NumDigits=4, ClkHz=100, ScanHz=10 → SlotCycles=10, BlankCycles=2, SegActiveLow=1, AnActiveLow=1):
- Reset held 3 cycles, then released with enable=0 -> an_out=4'b1111, seg_out=7'h7F, dp_out=1, frame_tick=0 throughout.
- enable=1, dig={7'h06,7'h5B,7'h4F,7'h66} (digit3..0), dp=4'b0001:
  - digit 0 is blank for 2 cycles, then driven for 8 cycles with an_out=4'b1110, seg_out=~7'h66, dp_out=0.
  - digits 1, 2, 3 follow in order; frame_tick fires at cycle 40 after enable.
- Change dig at cycle 15 of the frame -> seg_out keeps old values until frame_tick; new values appear from the next frame's digit 0.
- Drop enable during digit 2's DRIVE phase -> an_out=4'b1111 on the next edge; on re-enable the first driven anode is 4'b1110 after 2 blank cycles.
- Assert rst mid-DRIVE on digit 1 -> next edge gives an_out=4'b1111, index=0, no frame_tick.
- Rebuild with BlankCycles=0 -> no cycle with all anodes inactive while enabled; each anode is active 10 cycles per 40-cycle frame.
